// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control sequencer: steps fetch/decode/execute/mem/writeback
// and drives the shared ALU, register file and unified-memory controls.
// Ports: i_Clk, i_Rst (sync, active-high), i_Opcode (IR[31:26]), i_MemReady;
//   datapath enables/selects o_PCWrite..o_PCSource, debug o_State, o_Halted.
// Optional macro MC_PERF_CNT_EN adds o_InstrCount / o_CycleCount.
module mips_multicycle_ctrl #(
  parameter int WAIT_TIMEOUT = 16
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic [5:0] i_Opcode,
  input  logic       i_MemReady,
  output logic       o_PCWrite,
  output logic       o_PCWriteCond,
  output logic       o_PCWriteCondNe,
  output logic       o_IorD,
  output logic       o_MemRead,
  output logic       o_MemWrite,
  output logic       o_IRWrite,
  output logic       o_MemtoReg,
  output logic       o_RegDst,
  output logic       o_RegWrite,
  output logic       o_ALUSrcA,
  output logic [1:0] o_ALUSrcB,
  output logic [1:0] o_ALUOp,
  output logic [1:0] o_PCSource,
  output logic [3:0] o_State,
  output logic       o_Halted
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0] o_InstrCount,
  output logic [31:0] o_CycleCount
`endif
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_HALT   = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // Wide enough to hold WAIT_TIMEOUT itself.
  localparam int CW = $clog2(WAIT_TIMEOUT + 2);

  state_t          r_State;
  state_t          w_Next;
  logic [CW-1:0]   r_WaitCnt;
  logic [CW-1:0]   w_WaitInc;
  logic            w_IsMem;
  logic            w_Timeout;

  assign w_IsMem = (r_State == S_FETCH) || (r_State == S_MEMRD) ||
                   (r_State == S_MEMWR);
  assign w_WaitInc = r_WaitCnt + 1'b1;
  // A ready in the limit cycle completes the access instead of faulting.
  assign w_Timeout = (WAIT_TIMEOUT != 0) && w_IsMem && !i_MemReady &&
                     (w_WaitInc == CW'(WAIT_TIMEOUT));

  always_comb begin
    w_Next = r_State;
    case (r_State)
      S_FETCH:  if (i_MemReady) w_Next = S_DECODE;
      S_DECODE: begin
        case (i_Opcode)
          OP_RTYPE:      w_Next = S_EXEC;
          OP_LW, OP_SW:  w_Next = S_MEMADR;
          OP_BEQ, OP_BNE: w_Next = S_BRANCH;
          OP_J:          w_Next = S_JUMP;
          OP_ADDI:       w_Next = S_ADDIEX;
          default:       w_Next = S_HALT;
        endcase
      end
      S_MEMADR: w_Next = (i_Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (i_MemReady) w_Next = S_MEMWB;
      S_MEMWB:  w_Next = S_FETCH;
      S_MEMWR:  if (i_MemReady) w_Next = S_FETCH;
      S_EXEC:   w_Next = S_RWB;
      S_RWB:    w_Next = S_FETCH;
      S_BRANCH: w_Next = S_FETCH;
      S_JUMP:   w_Next = S_FETCH;
      S_ADDIEX: w_Next = S_ADDIWB;
      S_ADDIWB: w_Next = S_FETCH;
      default:  w_Next = S_HALT;
    endcase
    if (w_Timeout) w_Next = S_HALT;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_State   <= S_FETCH;
      r_WaitCnt <= '0;
    end else begin
      r_State <= w_Next;
      if (w_Next != r_State)
        r_WaitCnt <= '0;
      else if (w_IsMem && !i_MemReady)
        r_WaitCnt <= w_WaitInc;
    end
  end

  // Outputs decode the registered state; reset forces every output low so
  // an interrupted instruction issues no partial write.
  always_comb begin
    o_PCWrite       = 1'b0;
    o_PCWriteCond   = 1'b0;
    o_PCWriteCondNe = 1'b0;
    o_IorD          = 1'b0;
    o_MemRead       = 1'b0;
    o_MemWrite      = 1'b0;
    o_IRWrite       = 1'b0;
    o_MemtoReg      = 1'b0;
    o_RegDst        = 1'b0;
    o_RegWrite      = 1'b0;
    o_ALUSrcA       = 1'b0;
    o_ALUSrcB       = 2'b00;
    o_ALUOp         = 2'b00;
    o_PCSource      = 2'b00;
    o_Halted        = 1'b0;
    o_State         = 4'h0;
    if (!i_Rst) begin
      o_State = r_State;
      case (r_State)
        S_FETCH: begin
          o_MemRead = 1'b1;
          o_ALUSrcB = 2'b01;
          o_IRWrite = i_MemReady;
          o_PCWrite = i_MemReady;
        end
        S_DECODE: o_ALUSrcB = 2'b11;
        S_MEMADR: begin
          o_ALUSrcA = 1'b1;
          o_ALUSrcB = 2'b10;
        end
        S_MEMRD: begin
          o_MemRead = 1'b1;
          o_IorD    = 1'b1;
        end
        S_MEMWB: begin
          o_RegWrite = 1'b1;
          o_MemtoReg = 1'b1;
        end
        S_MEMWR: begin
          o_MemWrite = 1'b1;
          o_IorD     = 1'b1;
        end
        S_EXEC: begin
          o_ALUSrcA = 1'b1;
          o_ALUOp   = 2'b10;
        end
        S_RWB: begin
          o_RegWrite = 1'b1;
          o_RegDst   = 1'b1;
        end
        S_BRANCH: begin
          o_ALUSrcA       = 1'b1;
          o_ALUOp         = 2'b01;
          o_PCSource      = 2'b01;
          o_PCWriteCond   = (i_Opcode == OP_BEQ);
          o_PCWriteCondNe = (i_Opcode == OP_BNE);
        end
        S_JUMP: begin
          o_PCWrite  = 1'b1;
          o_PCSource = 2'b10;
        end
        S_ADDIEX: begin
          o_ALUSrcA = 1'b1;
          o_ALUSrcB = 2'b10;
        end
        S_ADDIWB: o_RegWrite = 1'b1;
        S_HALT:   o_Halted   = 1'b1;
        default:  o_Halted   = 1'b0;
      endcase
    end
  end

`ifdef MC_PERF_CNT_EN
  logic [31:0] r_InstrCount;
  logic [31:0] r_CycleCount;
  logic        w_Retire;

  assign w_Retire = (w_Next == S_FETCH) &&
                    ((r_State == S_MEMWB) || (r_State == S_MEMWR) ||
                     (r_State == S_RWB) || (r_State == S_BRANCH) ||
                     (r_State == S_JUMP) || (r_State == S_ADDIWB));

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_InstrCount <= '0;
      r_CycleCount <= '0;
    end else begin
      if (w_Retire) r_InstrCount <= r_InstrCount + 32'd1;
      if (r_State != S_HALT) r_CycleCount <= r_CycleCount + 32'd1;
    end
  end

  assign o_InstrCount = i_Rst ? 32'd0 : r_InstrCount;
  assign o_CycleCount = i_Rst ? 32'd0 : r_CycleCount;
`endif

endmodule
